// File: rtl/wshb_sdram_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone SDRAM arbiter.
package wshb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_sdram_arbiter_if.sv
// Wishbone bus bundle; the master modport drives requests, the slave modport drives responses.
interface wshb_if #(
   parameter int DATA_BYTES = 4,
   parameter int ADR_W      = 32
);
   localparam int DW = 8 * DATA_BYTES;

   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [ADR_W-1:0]      adr;
   logic [DW-1:0]         dat_ms;
   logic [DW-1:0]         dat_sm;
   logic [DATA_BYTES-1:0] sel;
   logic [2:0]            cti;
   logic [1:0]            bte;
   logic                  ack;
   logic                  err;
   logic                  rty;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wshb_sdram_arbiter_watchdog.sv
// Stall watchdog: counts strobe cycles without a slave response and fires a one-cycle error.
module wshb_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic stb,
   input  logic resp,
   input  logic clr,
   output logic fire
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] wdog;

   // A real slave response in the limit cycle takes priority over the forced error.
   assign fire = stb && !resp && (wdog == LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wdog <= '0;
      end else if (clr || !stb || resp || fire) begin
         wdog <= '0;
      end else begin
         wdog <= wdog + 1'b1;
      end
   end
endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Round-robin arbiter sharing one Wishbone SDRAM slave between a video reader (m0) and a writer (m1).
module wshb_sdram_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   wshb_if.slave      m0,
   wshb_if.slave      m1,
   wshb_if.master     s,
   output logic [1:0] grant,
   output logic       timeout_evt
);
   arb_state_t state;
   arb_state_t state_d;
   logic       last;
   logic       fire;

   // Ownership only changes once the owner releases cyc, so bursts are never split.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state;
      unique case (state)
         IDLE: begin
            if (m0.cyc && m1.cyc) state_d = last ? OWN0 : OWN1;
            else if (m0.cyc)      state_d = OWN0;
            else if (m1.cyc)      state_d = OWN1;
         end
         OWN0:    if (!m0.cyc) state_d = m1.cyc ? OWN1 : IDLE;
         OWN1:    if (!m1.cyc) state_d = m0.cyc ? OWN0 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_d;
         if (state_d == OWN0) last <= 1'b0;
         if (state_d == OWN1) last <= 1'b1;
      end
   end

   assign grant = {state == OWN1, state == OWN0};

   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      s.adr    = '0;
      s.dat_ms = '0;
      s.sel    = '0;
      s.cti    = '0;
      s.bte    = '0;
      if (state == OWN0) begin
         s.cyc    = m0.cyc;
         s.stb    = m0.stb;
         s.we     = m0.we;
         s.adr    = m0.adr;
         s.dat_ms = m0.dat_ms;
         s.sel    = m0.sel;
         s.cti    = m0.cti;
         s.bte    = m0.bte;
      end else if (state == OWN1) begin
         s.cyc    = m1.cyc;
         s.stb    = m1.stb;
         s.we     = m1.we;
         s.adr    = m1.adr;
         s.dat_ms = m1.dat_ms;
         s.sel    = m1.sel;
         s.cti    = m1.cti;
         s.bte    = m1.bte;
      end
   end

   // Responses are kept in a separate block from the request mux since fire depends on s.stb.
   always_comb begin
      m0.ack = 1'b0;
      m0.err = 1'b0;
      m0.rty = 1'b0;
      m1.ack = 1'b0;
      m1.err = 1'b0;
      m1.rty = 1'b0;
      if (state == OWN0) begin
         m0.ack = s.ack;
         m0.err = s.err | fire;
         m0.rty = s.rty;
      end else if (state == OWN1) begin
         m1.ack = s.ack;
         m1.err = s.err | fire;
         m1.rty = s.rty;
      end
   end

   assign m0.dat_sm   = s.dat_sm;
   assign m1.dat_sm   = s.dat_sm;
   assign timeout_evt = fire;

   wshb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .stb       (s.stb),
      .resp      (s.ack | s.err | s.rty),
      .clr       (state_d != state),
      .fire      (fire)
   );
endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-level ownership model.
module tb_wshb_sdram_arbiter;
   import wshb_arb_pkg::*;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant;
   logic       timeout_evt;

   wshb_if #(.DATA_BYTES(4), .ADR_W(32)) m0_bus ();
   wshb_if #(.DATA_BYTES(4), .ADR_W(32)) m1_bus ();
   wshb_if #(.DATA_BYTES(4), .ADR_W(32)) s_bus ();

   wshb_sdram_arbiter #(.TIMEOUT(TO)) dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .m0          (m0_bus),
      .m1          (m1_bus),
      .s           (s_bus),
      .grant       (grant),
      .timeout_evt (timeout_evt)
   );

   always #5 clk = ~clk;

   // Stimulus held by the bench for both masters and the slave.
   logic        mc[2], ms[2], mw[2];
   logic [31:0] ma[2], md[2];
   logic [3:0]  msel[2];
   logic [2:0]  mcti[2];
   logic [1:0]  mbte[2];
   logic        sa, se, sr;
   logic [31:0] sd;

   // Reference model: current owner (-1 none), last served master, stalled-strobe count.
   int   own, lst, wd;
   logic e_stb, e_resp, e_fire;
   logic obs_evt, obs_err0, obs_ack0, obs_ack1;
   logic [31:0] obs_dat0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      own = -1;
      lst = 1;
      wd  = 0;
   endtask

   task automatic drive();
      m0_bus.cyc = mc[0]; m0_bus.stb = ms[0]; m0_bus.we = mw[0]; m0_bus.adr = ma[0];
      m0_bus.dat_ms = md[0]; m0_bus.sel = msel[0]; m0_bus.cti = mcti[0]; m0_bus.bte = mbte[0];
      m1_bus.cyc = mc[1]; m1_bus.stb = ms[1]; m1_bus.we = mw[1]; m1_bus.adr = ma[1];
      m1_bus.dat_ms = md[1]; m1_bus.sel = msel[1]; m1_bus.cti = mcti[1]; m1_bus.bte = mbte[1];
      s_bus.ack = sa; s_bus.err = se; s_bus.rty = sr; s_bus.dat_sm = sd;
   endtask

   task automatic compare_all();
      logic [1:0]  eg;
      logic        ec, ew;
      logic [31:0] ea, ed;
      logic [3:0]  esel;
      logic [2:0]  ecti, r0, r1;
      logic [1:0]  ebte;
      eg = 2'b00; ec = 1'b0; e_stb = 1'b0; ew = 1'b0; ea = '0; ed = '0;
      esel = '0; ecti = '0; ebte = '0;
      if (own >= 0) begin
         eg = (own == 0) ? 2'b01 : 2'b10;
         ec = mc[own]; e_stb = ms[own]; ew = mw[own]; ea = ma[own]; ed = md[own];
         esel = msel[own]; ecti = mcti[own]; ebte = mbte[own];
      end
      e_resp = sa | se | sr;
      e_fire = e_stb && !e_resp && (wd == TO - 1);
      r0 = (own == 0) ? {sa, se | e_fire, sr} : 3'b000;
      r1 = (own == 1) ? {sa, se | e_fire, sr} : 3'b000;
      check("grant", 64'(grant), 64'(eg));
      check("s_ctl", 64'({s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.cti, s_bus.bte}),
            64'({ec, e_stb, ew, esel, ecti, ebte}));
      check("s_adr", 64'(s_bus.adr), 64'(ea));
      check("s_dat", 64'(s_bus.dat_ms), 64'(ed));
      check("m0_rsp", 64'({m0_bus.ack, m0_bus.err, m0_bus.rty}), 64'(r0));
      check("m1_rsp", 64'({m1_bus.ack, m1_bus.err, m1_bus.rty}), 64'(r1));
      check("m_dat", {m0_bus.dat_sm, m1_bus.dat_sm}, {sd, sd});
      check("evt", 64'(timeout_evt), 64'(e_fire));
      obs_evt = timeout_evt; obs_err0 = m0_bus.err; obs_ack0 = m0_bus.ack;
      obs_ack1 = m1_bus.ack; obs_dat0 = m0_bus.dat_sm;
   endtask

   task automatic model_advance();
      int nxt;
      if (!rst_n) begin
         model_reset();
         return;
      end
      nxt = own;
      if (own >= 0) begin
         if (!mc[own]) nxt = mc[1 - own] ? 1 - own : -1;
      end else if (mc[0] && mc[1]) nxt = 1 - lst;
      else if (mc[0]) nxt = 0;
      else if (mc[1]) nxt = 1;
      if (nxt != own || !e_stb || e_resp || e_fire) wd = 0;
      else wd++;
      if (nxt >= 0 && nxt != own) lst = nxt;
      own = nxt;
   endtask

   // Called at posedge+1: drive, check mid-cycle, then advance the model past the next edge.
   task automatic step();
      drive();
      #2;
      if (!rst_n) model_reset();
      compare_all();
      @(posedge clk);
      #1;
      model_advance();
   endtask

   task automatic idle_masters();
      for (int i = 0; i < 2; i++) begin
         mc[i] = 1'b0; ms[i] = 1'b0; mw[i] = 1'b0; ma[i] = '0; md[i] = '0;
         msel[i] = 4'hF; mcti[i] = CTI_CLASSIC; mbte[i] = 2'b00;
      end
      sa = 1'b0; se = 1'b0; sr = 1'b0; sd = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic rand_cycle(input bit silent);
      for (int i = 0; i < 2; i++) begin
         if (mc[i]) begin
            if ($urandom_range(7) == 0) begin
               mc[i] = 1'b0; ms[i] = 1'b0;
            end else begin
               ms[i] = silent ? 1'b1 : ($urandom_range(3) != 0);
            end
         end else if ($urandom_range(3) == 0) begin
            mc[i] = 1'b1; ms[i] = 1'b1;
         end else begin
            ms[i] = ($urandom_range(15) == 0);
         end
         mw[i]   = 1'($urandom_range(1));
         ma[i]   = $urandom;
         md[i]   = $urandom;
         msel[i] = 4'($urandom);
         mbte[i] = 2'($urandom);
         case ($urandom_range(2))
            0:       mcti[i] = CTI_CLASSIC;
            1:       mcti[i] = CTI_INCR;
            default: mcti[i] = CTI_EOB;
         endcase
      end
      sa = silent ? 1'b0 : ($urandom_range(2) == 0);
      se = silent ? 1'b0 : ($urandom_range(15) == 0);
      sr = silent ? 1'b0 : ($urandom_range(15) == 0);
      sd = $urandom;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      int cur;
      idle_masters();
      model_reset();
      rst_n = 1'b0;
      drive();
      @(posedge clk);
      #1;

      // Reset held with both masters requesting and a slave ack present.
      mc[0] = 1'b1; ms[0] = 1'b1; mc[1] = 1'b1; ms[1] = 1'b1; sa = 1'b1;
      repeat (3) step();
      check("t1_grant", 64'(grant), 64'(2'b00));
      check("t1_scyc", 64'(s_bus.cyc), 64'(1'b0));
      check("t1_acks", 64'({m0_bus.ack, m1_bus.ack}), 64'(2'b00));
      idle_masters();
      rst_n = 1'b1;
      step();

      // Single m0 read at 0x100.
      mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h100;
      step();
      check("t2_grant", 64'(grant), 64'(2'b01));
      sa = 1'b1; sd = 32'hCAFEF00D;
      step();
      check("t2_ack0", 64'(obs_ack0), 64'(1'b1));
      check("t2_ack1", 64'(obs_ack1), 64'(1'b0));
      check("t2_dat", 64'(obs_dat0), 64'(32'hCAFEF00D));
      idle_masters();
      step();

      // Both request after reset: m0 first, 8-beat burst unbroken, then m1.
      apply_reset();
      mc[0] = 1'b1; ms[0] = 1'b1; mc[1] = 1'b1; ms[1] = 1'b1;
      step();
      check("t3_first", 64'(grant), 64'(2'b01));
      for (int b = 0; b < 8; b++) begin
         mcti[0] = (b == 7) ? CTI_EOB : CTI_INCR;
         ma[0] = 32'h2000 + 32'(4 * b);
         sa = 1'b1;
         step();
         check("t3_hold", 64'(grant), 64'(2'b01));
      end
      mc[0] = 1'b0; ms[0] = 1'b0; sa = 1'b0;
      step();
      check("t3_hand", 64'(grant), 64'(2'b10));

      // Fairness: owner holds 20 cycles, drops cyc for one, ownership alternates.
      mc[0] = 1'b1; ms[0] = 1'b1; sa = 1'b1;
      cur = 1;
      for (int r = 0; r < 4; r++) begin
         repeat (20) step();
         mc[cur] = 1'b0; ms[cur] = 1'b0;
         step();
         check("t4_alt", 64'(grant), (cur == 1) ? 64'(2'b01) : 64'(2'b10));
         mc[cur] = 1'b1; ms[cur] = 1'b1;
         cur = 1 - cur;
      end
      idle_masters();
      step();

      // Watchdog: silent slave fires on strobe cycle TO; a response on that cycle wins.
      apply_reset();
      mc[0] = 1'b1; ms[0] = 1'b1;
      step();
      for (int k = 1; k <= TO; k++) begin
         step();
         check("t5_evt", 64'(obs_evt), 64'(k == TO));
         check("t5_err", 64'(obs_err0), 64'(k == TO));
      end
      ms[0] = 1'b0;
      step();
      ms[0] = 1'b1;
      for (int k = 1; k <= TO; k++) begin
         sa = (k == TO);
         step();
      end
      check("t5_ack_evt", 64'(obs_evt), 64'(1'b0));
      check("t5_ack_err", 64'({obs_err0, obs_ack0}), 64'(2'b01));
      idle_masters();
      step();

      // Async reset in the middle of an m1 burst.
      apply_reset();
      mc[1] = 1'b1; ms[1] = 1'b1; mcti[1] = CTI_INCR; sa = 1'b1;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("t6_scyc", 64'(s_bus.cyc), 64'(1'b0));
      check("t6_grant", 64'(grant), 64'(2'b00));
      step();
      mc[0] = 1'b1; ms[0] = 1'b1;
      rst_n = 1'b1;
      step();
      check("t6_first", 64'(grant), 64'(2'b01));
      idle_masters();
      step();

      // Randomized traffic, alternating responsive and silent slave phases.
      for (int c = 0; c < 3000; c++) begin
         rand_cycle(((c / 250) % 2) == 1);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
